// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | pipe_stage_buf : two-entry (main + skid) pipeline buffer with flush, hold,
// |                  occupancy and saturating stall counter.   Rev 1.0
// +----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              hold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              enq;
    logic              deq;

    // Handshakes depend only on state and hold, never on the opposite side.
    assign in_ready  = !hold && (state != FULL);
    assign out_valid = !hold && (state != EMPTY);
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready;
    assign occupancy = (state == FULL) ? 2'd2 : ((state == ONE) ? 2'd1 : 2'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else if (flush) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            // hold forces enq and deq low, so no explicit freeze branch is needed
            case (state)
                EMPTY: begin
                    if (enq) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (enq && deq) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (enq) begin
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        state     <= FULL;
                    end else if (deq) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deq) begin
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Flush intentionally leaves the stall statistic untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((state != EMPTY) && !hold && !out_ready && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_pipe_stage_buf : randomized scoreboard bench for pipe_stage_buf.  Rev 1.0
// +----------------------------------------------------------------------------
module tb_pipe_stage_buf;

    localparam int DW = 32;
    localparam int CW = 8;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          hold;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the queue holds every accepted, not-yet-consumed entry.
    logic [CW+DW-1:0] exp_q[$];
    int               stall_m = 0;
    bit               zero_m  = 1'b1;
    int               tests   = 0;
    int               fails   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit iv, input logic [CW-1:0] c, input logic [DW-1:0] d,
                         input bit ordy, input bit h, input bit f);
        bit               enq_m;
        bit               inc_m;
        int               sz;
        logic [CW+DW-1:0] hd;
        @(negedge clk);
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        hold      = h;
        flush     = f;
        #1;
        sz = exp_q.size();
        check("occupancy", 64'(occupancy), 64'(sz));
        check("in_ready", 64'(in_ready), 64'(!h && sz < 2));
        check("out_valid", 64'(out_valid), 64'(!h && sz > 0));
        check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        if (!h && sz > 0) begin
            hd = exp_q[0];
            check("head_data", 64'(out_data), 64'(hd[DW-1:0]));
            check("head_ctrl", 64'(out_ctrl), 64'(hd[CW+DW-1:DW]));
        end else begin
            check("idle_ctrl", 64'(out_ctrl), 64'd0);
        end
        if (zero_m) check("zero_data", 64'(out_data), 64'd0);
        enq_m = iv && !h && sz < 2;
        inc_m = sz > 0 && !h && !ordy;
        @(posedge clk);
        #1;
        if (inc_m && stall_m < 3) stall_m++;
        if (f) begin
            exp_q.delete();
            zero_m = 1'b1;
        end else if (enq_m) begin
            exp_q.push_back({c, d});
            zero_m = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_ctrl"}, 64'(out_ctrl), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_occupancy"}, 64'(occupancy), 64'd0);
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'd0);
    endtask

    // Reset pulse strictly between edges; outputs must react before any clock edge.
    task automatic pulse_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hold      = 1'b0;
        flush     = 1'b0;
        #3 reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        reset = 1'b0;
        exp_q.delete();
        stall_m = 0;
        zero_m  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever a handshake will complete at the next edge.
    initial begin
        logic [CW+DW-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got data %0h with nothing expected at %0t",
                             out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_data", 64'(out_data), 64'(e[DW-1:0]));
                    check("mon_ctrl", 64'(out_ctrl), 64'(e[CW+DW-1:DW]));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        hold      = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        check_reset_outputs("init_rst");
        @(negedge clk);
        reset = 1'b0;

        // Streaming 1..10
        for (int i = 1; i <= 10; i++) cycle(1'b1, CW'(i), DW'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A then B fill both entries, then drain in order
        cycle(1'b1, 8'hA1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB2, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush while FULL with a concurrent entry C
        cycle(1'b1, 8'h11, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hCC, 32'hCCCC_CCCC, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Hold for three cycles in ONE, then release
        cycle(1'b1, 8'h55, 32'h5555_5555, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'h66, 32'h6666_6666, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Stall counter saturation, flush retention, reset clear
        pulse_reset();
        cycle(1'b1, 8'h77, 32'h7777_7777, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset while FULL, then immediate enqueue
        cycle(1'b1, 8'h81, 32'h8181_8181, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h82, 32'h8282_8282, 1'b0, 1'b0, 1'b0);
        pulse_reset();
        cycle(1'b1, 8'h83, 32'h8383_8383, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit iv, ordy, h, f;
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 3) != 0);
            h    = ($urandom_range(0, 9) == 0);
            f    = ($urandom_range(0, 29) == 0);
            cycle(iv, CW'($urandom), DW'($urandom), ordy, h, f);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of the datapath payload (operands, immediates, PCs).
REQ-002 SHALL have parameter CTRL_W, default 24, width of the control payload (write enables, op selects); at least 1.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter; at least 2.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous wash: discard all held entries.
REQ-007 SHALL have port hold, input, 1, synchronous freeze: no enqueue, no dequeue.
REQ-008 SHALL have port in_valid, input, 1, upstream entry present.
REQ-009 SHALL have port in_ready, output, 1, stage can accept an entry this cycle.
REQ-010 SHALL have port in_ctrl, input, CTRL_W, control payload.
REQ-011 SHALL have port in_data, input, DATA_W, datapath payload.
REQ-012 SHALL have port out_valid, output, 1, entry presented downstream.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the entry.
REQ-014 SHALL have port out_ctrl, output, CTRL_W, control payload; all-zero whenever out_valid=0.
REQ-015 SHALL have port out_data, output, DATA_W, datapath payload of the head entry.
REQ-016 SHALL have port occupancy, output, 2, number of held entries (0..2).
REQ-017 SHALL have port stall_cnt, output, CNT_W, saturating count of backpressure cycles.

Function
REQ-018 SHALL hold two entries, main (head) and skid, with a 3-state FSM: EMPTY (0 entries), ONE (main), FULL (main and skid).
REQ-019 SHALL drive in_ready = !hold AND state != FULL; in_ready SHALL NOT depend combinationally on out_ready.
REQ-020 SHALL drive out_valid = !hold AND state != EMPTY; out_data and out_ctrl SHALL come from main.
REQ-021 SHALL define enq = in_valid AND in_ready, and deq = out_valid AND out_ready.
REQ-022 SHALL apply these transitions from EMPTY: enq -> ONE with main <= in; otherwise stay.
REQ-023 SHALL apply these transitions from ONE: enq AND deq -> ONE with main <= in; enq only -> FULL with skid <= in; deq only -> EMPTY; neither -> stay.
REQ-024 SHALL apply these transitions from FULL: deq -> ONE with main <= skid; otherwise stay (enq is impossible).
REQ-025 SHALL give one-cycle latency: an entry enqueued at edge N is visible on out_* after edge N, in the same cycle if downstream is ready.
REQ-026 SHALL preserve order and SHALL never drop or duplicate an entry except on flush.
REQ-027 SHALL, on flush=1, go to EMPTY and zero main and skid (ctrl and data) at that edge, regardless of in_valid, out_ready or hold; an enq in that cycle SHALL be discarded.
REQ-028 SHALL give flush priority over hold; with hold=1 and flush=0, state, main and skid SHALL stay unchanged.
REQ-029 SHALL drive occupancy as 0 in EMPTY, 1 in ONE and 2 in FULL.
REQ-030 SHALL increment stall_cnt by 1 on each edge where state != EMPTY, hold=0 and out_ready=0; it SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-031 SHALL NOT let flush clear stall_cnt.
REQ-032 SHALL place no combinational path from in_* to out_*; all out_* and in_ready SHALL be register- or hold-derived only.

Reset
REQ-033 SHALL, on reset=1 and independent of clk, force state to EMPTY, main and skid to all-zero and stall_cnt to 0.
REQ-034 SHALL therefore output in_ready=1 (if hold=0), out_valid=0, out_ctrl=0, out_data=0, occupancy=0 and stall_cnt=0 during reset.
REQ-035 SHALL, on reset asserted mid-transfer (state FULL), lose all entries with no enq or deq recorded; first enq is allowed at the first edge after deassertion.

Verification
REQ-036 SHALL cover streaming: in_valid=1 and out_ready=1 for 10 cycles with data 1..10 -> out_data 1..10 on consecutive cycles, occupancy=1, stall_cnt=0.
REQ-037 SHALL cover backpressure: out_ready=0 and enqueue A then B -> occupancy=2, in_ready=0, out_data=A; out_ready=1 -> A then B, in_ready=1 one cycle after the first deq.
REQ-038 SHALL cover flush while FULL with concurrent in_valid (C) -> next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0, C never emitted.
REQ-039 SHALL cover hold=1 for 3 cycles in ONE with out_ready=1 -> out_valid=0, in_ready=0, main unchanged; hold=0 -> original entry emitted once.
REQ-040 SHALL cover saturation: CNT_W=2, out_valid=1, out_ready=0 for 6 cycles -> stall_cnt 1,2,3,3,3,3; flush leaves it 3; reset sets it to 0.
REQ-041 SHALL cover asynchronous reset pulse between edges while FULL -> outputs match REQ-034 immediately, before the next clk edge.
